sbm_mult_arbiter: RTL and testbench
===================================

// Module: sbm_mult_arbiter
// PURPOSE
// - Shares one digit-serial multiplier (start/done, clear-after-use protocol) between NREQ requesters.
// - Round-robin arbitration; one operation in flight at a time.
// - Accepts {a,b} per requester via valid/ready; returns product, requester id and error flag on a
//   single response channel.
// - Sits between the crypto/bignum datapath clients and the shared multiplier instance.
// PARAMETERS
// - SIZEA    1024  operand A width (bits)
// - SIZEB    1024  operand B width (bits)
// - NREQ     4     number of requesters (2..16)
// - IDW      2     requester id width, = clog2(NREQ)
// - TIMEOUT  4096  max cycles waiting for mul_done before abort
// PORTS
// - clk        in   1              clock
// - rst        in   1              synchronous, active-high reset
// - req_valid  in   NREQ           request pending, per requester
// - req_ready  out  NREQ           one-hot accept pulse
// - req_a      in   NREQ*SIZEA     operand A, requester i at [i*SIZEA +: SIZEA]
// - req_b      in   NREQ*SIZEB     operand B, requester i at [i*SIZEB +: SIZEB]
// - mul_a      out  SIZEA          operand A to shared multiplier (registered)
// - mul_b      out  SIZEB          operand B to shared multiplier (registered)
// - mul_start  out  1              level start to multiplier
// - mul_clr    out  1              one-cycle local clear to multiplier
// - mul_done   in   1              multiplier result valid (level)
// - mul_c      in   SIZEA+SIZEB    multiplier product
// - rsp_valid  out  1              response valid
// - rsp_ready  in   1              response consumer ready
// - rsp_id     out  IDW            requester index of response
// - rsp_c      out  SIZEA+SIZEB    product (zero on error)
// - rsp_err    out  1              1 = timeout abort
// - busy       out  1              1 whenever state != IDLE
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; rr_ptr 0; timeout counter 0.
// - FSM states: IDLE -> ISSUE -> BUSY -> CLEAR -> RESP -> IDLE.
// - IDLE: if |req_valid, grant = first set bit searching rr_ptr, rr_ptr+1, ... (mod NREQ).
//   - req_ready[grant] = 1 for exactly this cycle (combinational).
//   - Operands and grant id are latched into mul_a/mul_b/rsp_id at the clock edge.
//   - Next state ISSUE. With no request, remain in IDLE.
// - ISSUE: mul_start = 1; timeout counter cleared; next state BUSY. mul_done is ignored in ISSUE.
// - BUSY: mul_start stays 1; counter increments every cycle.
//   - On mul_done = 1: capture mul_c into rsp_c, rsp_err = 0, go to CLEAR.
//   - If the counter reaches TIMEOUT-1 without done: rsp_c = 0, rsp_err = 1, go to CLEAR.
//   - If done and timeout coincide, done wins.
// - CLEAR: mul_start = 0; mul_clr = 1 for this single cycle; next state RESP.
// - RESP: rsp_valid = 1 and rsp_id/rsp_c/rsp_err are held stable until rsp_ready = 1.
//   - On the handshake cycle: rr_ptr = (rsp_id+1) mod NREQ, go to IDLE.
//   - No new grant is issued in the handshake cycle.
// - Latency, accept to rsp_valid: 1 (ISSUE) + k (BUSY, k = cycles until done, >= 1) + 1 (CLEAR) + 1.
// - Requester inputs may change freely once req_ready has pulsed; the latched copy is used.
// - req_valid deasserting before grant is legal: that requester is simply skipped.
// - Reset mid-operation: immediate return to IDLE with all outputs 0.
//   - mul_clr is not asserted; the multiplier is expected to share rst.
// - rsp_c width is SIZEA+SIZEB with no truncation; mul_c is passed through unmodified.
// TESTING
// - Single requester 1, a=0x3, b=0x5 (SIZEA=SIZEB=8), model done after 4 cycles
//   -> req_ready[1] pulse, rsp_id=1, rsp_c=0x000F, rsp_err=0, mul_clr pulse once.
// - All 4 requesters valid continuously
//   -> grant order 0,1,2,3,0; each rsp_id matches; exactly one op in flight.
// - rsp_ready held 0 for 10 cycles in RESP -> rsp_* stable, no req_ready pulse, then IDLE after handshake.
// - TIMEOUT=16, model never asserts done -> rsp_err=1, rsp_c=0, mul_clr pulse at cycle 17 after ISSUE.
// - Done and timeout in the same cycle -> rsp_err=0 and rsp_c = mul_c.
// - rst asserted during BUSY -> next cycle all outputs 0, busy=0; a fresh request is granted to req 0 first.

Source files
------------

// File: rtl/sbm_mult_arbiter_if.sv
// Requester, shared-multiplier and response channels of the multiplier arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface sbm_mult_arbiter_if #(
  parameter int unsigned SIZEA = 1024,
  parameter int unsigned SIZEB = 1024,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = 2
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*SIZEA-1:0]  req_a;
  logic [NREQ*SIZEB-1:0]  req_b;
  logic [SIZEA-1:0]       mul_a;
  logic [SIZEB-1:0]       mul_b;
  logic                   mul_start;
  logic                   mul_clr;
  logic                   mul_done;
  logic [SIZEA+SIZEB-1:0] mul_c;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [SIZEA+SIZEB-1:0] rsp_c;
  logic                   rsp_err;

  modport master (
    output req_valid, req_a, req_b, mul_done, mul_c, rsp_ready,
    input  req_ready, mul_a, mul_b, mul_start, mul_clr, rsp_valid, rsp_id, rsp_c, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, mul_done, mul_c, rsp_ready,
    output req_ready, mul_a, mul_b, mul_start, mul_clr, rsp_valid, rsp_id, rsp_c, rsp_err
  );
endinterface

// File: rtl/sbm_mult_arbiter.sv
// Round-robin arbiter sharing one start/done/clear multiplier between NREQ requesters,
// with a timeout abort and a single held response channel.
module sbm_mult_arbiter #(
  parameter int unsigned SIZEA   = 1024,
  parameter int unsigned SIZEB   = 1024,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst,
  sbm_mult_arbiter_if.slave   bus,
  output logic                busy
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam int unsigned PW = SIZEA + SIZEB;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    BUSY  = 3'd2,
    CLEAR = 3'd3,
    RESP  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            grant_vld_c;
  logic [IDW-1:0]  grant_id_c;
  logic            grant_en;
  logic            cap_en;
  logic [PW-1:0]   rsp_c_d;
  logic            rsp_err_d;

  logic [SIZEA-1:0] mul_a_q;
  logic [SIZEB-1:0] mul_b_q;
  logic             mul_start_q;
  logic             mul_clr_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [PW-1:0]    rsp_c_q;
  logic             rsp_err_q;
  logic             busy_q;

  logic [SIZEA-1:0] a_arr [NREQ];
  logic [SIZEB-1:0] b_arr [NREQ];

  // Per-requester views of the flattened operand buses
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = bus.req_a[g*SIZEA +: SIZEA];
    assign b_arr[g] = bus.req_b[g*SIZEB +: SIZEB];
  end

  // Round-robin search starting at rr_ptr, wrapping mod NREQ
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_vld_c = 1'b0;
    grant_id_c  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(rr_ptr_q) + i) % NREQ;
      if (!grant_vld_c && bus.req_valid[IDW'(idx)]) begin
        grant_vld_c = 1'b1;
        grant_id_c  = IDW'(idx);
      end
    end
  end

  // Next-state and datapath enables
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    grant_en  = 1'b0;
    cap_en    = 1'b0;
    rsp_c_d   = '0;
    rsp_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_vld_c) begin
          grant_en = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        // A done arriving on the last allowed cycle still wins over the abort
        if (bus.mul_done) begin
          cap_en  = 1'b1;
          rsp_c_d = bus.mul_c;
          state_d = CLEAR;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          cap_en    = 1'b1;
          rsp_err_d = 1'b1;
          state_d   = CLEAR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLEAR: state_d = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          rr_ptr_d = (rsp_id_q == IDW'(NREQ - 1)) ? '0 : rsp_id_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Accept pulse is combinational so the requester sees it in the grant cycle
  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && grant_vld_c) begin
      bus.req_ready = NREQ'(1) << grant_id_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_start_q <= 1'b0;
      mul_clr_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_c_q     <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      mul_start_q <= (state_d == ISSUE) || (state_d == BUSY);
      mul_clr_q   <= (state_d == CLEAR);
      rsp_valid_q <= (state_d == RESP);
      busy_q      <= (state_d != IDLE);
      if (grant_en) begin
        mul_a_q  <= a_arr[grant_id_c];
        mul_b_q  <= b_arr[grant_id_c];
        rsp_id_q <= grant_id_c;
      end
      if (cap_en) begin
        rsp_c_q   <= rsp_c_d;
        rsp_err_q <= rsp_err_d;
      end
    end
  end

  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.mul_start = mul_start_q;
  assign bus.mul_clr   = mul_clr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_sbm_mult_arbiter.sv
// Scoreboard bench for sbm_mult_arbiter: randomized requesters, a behavioural multiplier
// with per-operation done delay, and a monitor checking grants, clears and responses.
module tb_sbm_mult_arbiter;
  localparam int unsigned SIZEA   = 8;
  localparam int unsigned SIZEB   = 8;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned IDW     = 2;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned PW      = SIZEA + SIZEB;

  typedef struct {
    logic [SIZEA-1:0] a;
    logic [SIZEB-1:0] b;
    int               d;   // busy cycles until done; 0 = never
  } op_t;

  typedef struct {
    int            id;
    logic [PW-1:0] c;
    logic          err;
    int            lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  sbm_mult_arbiter_if #(.SIZEA(SIZEA), .SIZEB(SIZEB), .NREQ(NREQ), .IDW(IDW)) bus ();

  sbm_mult_arbiter #(
    .SIZEA(SIZEA), .SIZEB(SIZEB), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  op_t  pend [NREQ][$];
  exp_t sb [$];
  int   grant_log [$];

  int   valid_pct = 100;
  int   rdy_mode  = 1;     // 0 random, 1 always, 2 hold ten cycles
  int   hold_cnt  = 0;
  logic in_flight = 1'b0;
  int   rr_ref    = 0;
  int   exp_clr   = -1;
  int   cur_delay = 0;
  int   rsp_count = 0;
  int   clr_count = 0;
  int   stable_cnt = 0;
  logic post_rst  = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic [IDW+PW:0] held;
  logic [IDW-1:0]  last_id;
  logic [PW-1:0]   last_c;
  logic            last_err;

  logic [SIZEA-1:0] a_drv [NREQ];
  logic [SIZEB-1:0] b_drv [NREQ];
  logic [NREQ-1:0]  v_drv   = '0;
  logic             rdy_drv = 1'b0;
  logic             done_m  = 1'b0;
  logic [PW-1:0]    c_m     = '0;
  int               mcnt    = 0;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_drv
    assign bus.req_a[gi*SIZEA +: SIZEA] = a_drv[gi];
    assign bus.req_b[gi*SIZEB +: SIZEB] = b_drv[gi];
  end
  assign bus.req_valid = v_drv;
  assign bus.rsp_ready = rdy_drv;
  assign bus.mul_done  = done_m;
  assign bus.mul_c     = c_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_op(input int r, input logic [SIZEA-1:0] a, input logic [SIZEB-1:0] b,
                         input int d);
    op_t op;
    op.a = a;
    op.b = b;
    op.d = d;
    pend[IDW'(r)].push_back(op);
  endtask

  function automatic int pending_total();
    int n = 0;
    for (int i = 0; i < NREQ; i++) n += pend[IDW'(i)].size();
    return n;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while ((pending_total() > 0 || in_flight || sb.size() > 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d cycles expected fewer than %0d", n, budget);
    end
    repeat (3) @(posedge clk);
  endtask

  always @(posedge clk) cyc++;

  // Requester and response-consumer drivers
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (pend[IDW'(i)].size() > 0 && int'($urandom_range(99)) < valid_pct) begin
        v_drv[IDW'(i)] = 1'b1;
        a_drv[IDW'(i)] = pend[IDW'(i)][0].a;
        b_drv[IDW'(i)] = pend[IDW'(i)][0].b;
      end else begin
        v_drv[IDW'(i)] = 1'b0;
        a_drv[IDW'(i)] = SIZEA'($urandom);
        b_drv[IDW'(i)] = SIZEB'($urandom);
      end
    end
    case (rdy_mode)
      0: rdy_drv = 1'($urandom_range(1));
      1: rdy_drv = 1'b1;
      default: begin
        if (bus.rsp_valid) begin
          if (hold_cnt < 10) begin
            rdy_drv = 1'b0;
            hold_cnt++;
          end else begin
            rdy_drv = 1'b1;
          end
        end else begin
          rdy_drv  = 1'b0;
          hold_cnt = 0;
        end
      end
    endcase
  end

  // Shared multiplier: done after cur_delay started cycles, held until clear
  always @(posedge clk) begin
    if (rst || bus.mul_clr) begin
      mcnt   <= 0;
      done_m <= 1'b0;
      c_m    <= PW'($urandom);
    end else if (!done_m) begin
      if (bus.mul_start) begin
        mcnt <= mcnt + 1;
        if (cur_delay != 0 && mcnt + 1 == cur_delay) begin
          done_m <= 1'b1;
          c_m    <= PW'(bus.mul_a) * PW'(bus.mul_b);
        end else begin
          c_m <= PW'($urandom);
        end
      end else begin
        c_m <= PW'($urandom);
      end
    end
  end

  // Monitor: arbitration reference, clear timing and response scoreboard
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    int   g;
    int   k;
    int   j;
    op_t  op;
    exp_t e;
    if (rst) begin
      in_flight  = 1'b0;
      sb.delete();
      rr_ref     = 0;
      exp_clr    = -1;
      post_rst   = 1'b1;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (post_rst) begin
        chk("post_rst_mul_a",     64'(bus.mul_a),     64'(0));
        chk("post_rst_mul_b",     64'(bus.mul_b),     64'(0));
        chk("post_rst_mul_start", 64'(bus.mul_start), 64'(0));
        chk("post_rst_mul_clr",   64'(bus.mul_clr),   64'(0));
        chk("post_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("post_rst_rsp_id",    64'(bus.rsp_id),    64'(0));
        chk("post_rst_rsp_c",     64'(bus.rsp_c),     64'(0));
        chk("post_rst_rsp_err",   64'(bus.rsp_err),   64'(0));
        chk("post_rst_req_ready", 64'(bus.req_ready), 64'(0));
        post_rst = 1'b0;
      end
      chk("busy", 64'(busy), 64'(in_flight));

      exp_rdy = '0;
      if (!in_flight) begin
        for (int i = 0; i < NREQ; i++) begin
          j = (rr_ref + i) % NREQ;
          if (exp_rdy == '0 && bus.req_valid[IDW'(j)]) exp_rdy[IDW'(j)] = 1'b1;
        end
      end
      if (bus.req_ready != '0 || exp_rdy != '0)
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));

      g = -1;
      for (int i = 0; i < NREQ; i++)
        if (g < 0 && bus.req_ready[IDW'(i)] && bus.req_valid[IDW'(i)]) g = i;
      if (g >= 0 && !in_flight && pend[IDW'(g)].size() > 0) begin
        op    = pend[IDW'(g)].pop_front();
        e.id  = g;
        e.err = (op.d == 0 || op.d > int'(TIMEOUT));
        k     = e.err ? int'(TIMEOUT) : op.d;
        e.c   = e.err ? '0 : PW'(op.a) * PW'(op.b);
        e.lat = cyc + 3 + k;
        sb.push_back(e);
        grant_log.push_back(g);
        exp_clr   = cyc + 2 + k;
        cur_delay = op.d;
        in_flight = 1'b1;
        rr_ref    = (g + 1) % NREQ;
      end

      if (bus.mul_clr) begin
        clr_count++;
        chk("mul_clr_cycle", 64'(cyc), 64'(exp_clr));
        exp_clr = -1;
      end

      if (bus.rsp_valid) begin
        if (prev_valid && !prev_ready) begin
          stable_cnt++;
          chk("rsp_stable", 64'({bus.rsp_id, bus.rsp_c, bus.rsp_err}), 64'(held));
        end else if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected: got id %0d expected no response (cycle %0d)",
                   bus.rsp_id, cyc);
        end else begin
          e = sb.pop_front();
          chk("rsp_id",      64'(bus.rsp_id),  64'(e.id));
          chk("rsp_c",       64'(bus.rsp_c),   64'(e.c));
          chk("rsp_err",     64'(bus.rsp_err), 64'(e.err));
          chk("rsp_latency", 64'(cyc),         64'(e.lat));
          rsp_count++;
          last_id  = bus.rsp_id;
          last_c   = bus.rsp_c;
          last_err = bus.rsp_err;
        end
        held = {bus.rsp_id, bus.rsp_c, bus.rsp_err};
        if (bus.rsp_ready) in_flight = 1'b0;
      end
      prev_valid = bus.rsp_valid;
      prev_ready = bus.rsp_ready;
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got no end of test expected finish within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int s0;
    int n;
    for (int i = 0; i < NREQ; i++) begin
      a_drv[IDW'(i)] = '0;
      b_drv[IDW'(i)] = '0;
    end

    // Reset values while rst is held
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mul_a",     64'(bus.mul_a),     64'(0));
    chk("rst_mul_b",     64'(bus.mul_b),     64'(0));
    chk("rst_mul_start", 64'(bus.mul_start), 64'(0));
    chk("rst_mul_clr",   64'(bus.mul_clr),   64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_rsp_id",    64'(bus.rsp_id),    64'(0));
    chk("rst_rsp_c",     64'(bus.rsp_c),     64'(0));
    chk("rst_rsp_err",   64'(bus.rsp_err),   64'(0));
    chk("rst_busy",      64'(busy),          64'(0));
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    @(posedge clk);
    #2 rst = 1'b0;

    // All four requesters continuously valid
    valid_pct = 100;
    rdy_mode  = 1;
    grant_log.delete();
    for (int r = 0; r < NREQ; r++) begin
      push_op(r, SIZEA'($urandom), SIZEB'($urandom), int'($urandom_range(1, 6)));
      push_op(r, SIZEA'($urandom), SIZEB'($urandom), int'($urandom_range(1, 6)));
    end
    drain(2000);
    chk("order_len", 64'(grant_log.size() >= 5), 64'(1));
    if (grant_log.size() >= 5)
      for (int i = 0; i < 5; i++) chk("grant_order", 64'(grant_log[i]), 64'(exp_order[i]));

    // Single requester 1, 3 * 5
    grant_log.delete();
    push_op(1, 8'h03, 8'h05, 4);
    drain(500);
    chk("single_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(1));
    chk("single_id",    64'(last_id),  64'(1));
    chk("single_c",     64'(last_c),   64'(16'h000F));
    chk("single_err",   64'(last_err), 64'(0));

    // Response held off for ten cycles
    rdy_mode = 2;
    s0 = stable_cnt;
    push_op(2, 8'h21, 8'h42, 3);
    drain(500);
    chk("hold_cycles", 64'(stable_cnt - s0), 64'(10));
    rdy_mode = 1;

    // Multiplier never finishes
    push_op(3, 8'h77, 8'h11, 0);
    drain(500);
    chk("timeout_err", 64'(last_err), 64'(1));
    chk("timeout_c",   64'(last_c),   64'(0));

    // Done on the final allowed cycle
    push_op(0, 8'hFF, 8'hFF, TIMEOUT);
    drain(500);
    chk("edge_err", 64'(last_err), 64'(0));
    chk("edge_c",   64'(last_c),   64'(16'hFE01));

    // Randomized traffic with backpressure and flickering valids
    rdy_mode  = 0;
    valid_pct = 70;
    for (int i = 0; i < 60; i++) begin
      push_op(int'($urandom_range(NREQ - 1)), SIZEA'($urandom), SIZEB'($urandom),
              ($urandom_range(9) == 0) ? 0 : int'($urandom_range(1, 20)));
      if ($urandom_range(3) == 0) repeat ($urandom_range(1, 30)) @(posedge clk);
    end
    drain(20000);

    // Leave the round-robin pointer away from zero, then reset mid-operation
    valid_pct = 100;
    rdy_mode  = 1;
    push_op(1, 8'h05, 8'h06, 2);
    drain(500);
    push_op(2, 8'h09, 8'h09, 0);
    n = 0;
    while (!(busy && bus.mul_start) && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);

    grant_log.delete();
    for (int r = 0; r < NREQ; r++) push_op(r, SIZEA'($urandom), SIZEB'($urandom), 2);
    drain(2000);
    chk("post_rst_first_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(0));
    chk("clr_per_rsp", 64'(clr_count), 64'(rsp_count));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
